// File: rtl/rtype_encoder_if.sv
// rtype_encoder_if: request/issue bus between an ALU-op requester and rtype_encoder.
// Latency: none (wires only).
// Backpressure: in_ready gates requests; out_ready gates issue of encoded words.
//
// Signal summary:
//   in_valid/in_ready   request handshake; in_alu_op, in_rd, in_rs1, in_rs2 carry the request
//   out_valid/out_ready issue handshake; out_instr is the RV32I word at the FIFO head
//   illegal             one-cycle pulse after an unsupported ALUop was accepted and dropped
//   illegal_count       saturating count of dropped requests
//   count               current FIFO occupancy
interface rtype_encoder_if #(
   parameter int DEPTH = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [3:0]               in_alu_op;
   logic [4:0]               in_rd;
   logic [4:0]               in_rs1;
   logic [4:0]               in_rs2;
   logic                     out_valid;
   logic                     out_ready;
   logic [31:0]              out_instr;
   logic                     illegal;
   logic [7:0]               illegal_count;
   logic [$clog2(DEPTH):0]   count;

   // Requester / consumer side.
   modport master (
      output in_valid, in_alu_op, in_rd, in_rs1, in_rs2, out_ready,
      input  in_ready, out_valid, out_instr, illegal, illegal_count, count
   );

   // Encoder side.
   modport slave (
      input  in_valid, in_alu_op, in_rd, in_rs1, in_rs2, out_ready,
      output in_ready, out_valid, out_instr, illegal, illegal_count, count
   );
endinterface

// File: rtl/rtype_encoder.sv
// rtype_encoder: encodes {ALUop, rd, rs1, rs2} requests into RV32I R-type words and queues them.
// Latency: a word accepted at edge N is at the head (out_valid=1) after edge N; no bypass.
// Backpressure: in_ready = !full (depends on occupancy only); the head is held while out_ready=0.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards all queued words
//   bus    rtype_encoder_if.slave: request handshake in, issue handshake out,
//          illegal pulse, saturating illegal_count, FIFO occupancy count
module rtype_encoder #(
   parameter int DEPTH = 4   // FIFO entries, power of two, >= 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rtype_encoder_if.slave       bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [6:0] OPC_RTYPE = 7'b0110011;

   // ALUop codes as seen from the decoder side.
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SLL = 4'b0101;
   localparam logic [3:0] OP_SRL = 4'b0110;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [31:0]    r_mem [DEPTH];
   logic [AW-1:0]  r_wptr;
   logic [AW-1:0]  r_rptr;
   logic [CW-1:0]  r_count;
   logic           r_illegal;
   logic [7:0]     r_illegal_cnt;

   // ------------------------------------------------------------------
   // Combinational
   // ------------------------------------------------------------------
   logic           w_full;
   logic           w_empty;
   logic           w_accept;
   logic           w_legal;
   logic [2:0]     w_funct3;
   logic [6:0]     w_funct7;
   logic [31:0]    w_word;
   logic           w_push;
   logic           w_drop;
   logic           w_pop;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   // Illegal ops still complete the handshake; only the write is suppressed.
   assign w_accept = bus.in_valid & ~w_full;

   // ALUop -> funct3/funct7. Anything not listed is unsupported.
   always_comb begin
      w_legal  = 1'b1;
      w_funct3 = 3'b000;
      w_funct7 = 7'b0000000;
      unique case (bus.in_alu_op)
         OP_ADD: w_funct3 = 3'b000;
         OP_SUB: begin
            w_funct3 = 3'b000;
            w_funct7 = 7'b0100000;
         end
         OP_SLL: w_funct3 = 3'b001;
         OP_SRL: w_funct3 = 3'b101;
         OP_OR:  w_funct3 = 3'b110;
         OP_AND: w_funct3 = 3'b111;
         default: w_legal = 1'b0;
      endcase
   end

   // Register indices pass straight through, x0 included.
   assign w_word = {w_funct7, bus.in_rs2, bus.in_rs1, w_funct3, bus.in_rd, OPC_RTYPE};

   assign w_push = w_accept & w_legal;
   assign w_drop = w_accept & ~w_legal;
   // Pop is decided from registered occupancy only, so a word pushed into an
   // empty FIFO cannot leave on the same edge.
   assign w_pop  = ~w_empty & bus.out_ready;

   // ------------------------------------------------------------------
   // Storage: no reset needed, the head is masked by occupancy.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_word;
      end
   end

   // ------------------------------------------------------------------
   // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
   // modulo DEPTH by plain overflow.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Illegal-op reporting
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_illegal     <= 1'b0;
         r_illegal_cnt <= '0;
      end else begin
         r_illegal <= w_drop;
         if (w_drop && (r_illegal_cnt != 8'hFF)) begin
            r_illegal_cnt <= r_illegal_cnt + 8'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs: all derived from registered state.
   // ------------------------------------------------------------------
   assign bus.in_ready      = ~w_full;
   assign bus.out_valid     = ~w_empty;
   assign bus.out_instr     = w_empty ? 32'd0 : r_mem[r_rptr];
   assign bus.illegal       = r_illegal;
   assign bus.illegal_count = r_illegal_cnt;
   assign bus.count         = r_count;

   // Occupancy can never exceed the storage.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) r_count <= CW'(DEPTH));

endmodule

// File: doc/rtype_encoder.md
# rtype_encoder

Issue-side companion to the R-type control unit. Accepts abstract ALU-operation requests as {ALUop, rd, rs1, rs2}, encodes each into a 32-bit RV32I R-type instruction word, and buffers the words in a small FIFO. A valid/ready handshake feeds the words to the instruction/decode path. It is the encoder for the decoder's ALUop/funct mapping. Unsupported ALUop codes are rejected and counted.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept; equals !full
- in_alu_op  in  4  ALUop code: and=0000, or=0001, add=0010, sub=0100, sll=0101, srl=0110
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- out_valid  out  1  FIFO head holds a word
- out_ready  in  1  consumer takes head
- out_instr  out  32  encoded instruction at FIFO head; 0 when out_valid=0
- illegal  out  1  one-cycle pulse: an unsupported ALUop was accepted and dropped
- illegal_count  out  8  saturating count of dropped requests
- count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Accept: in_valid && in_ready at a rising edge.
- Legal op: encoded word is written at the write pointer.
- Encoding:
  - instr[6:0] = 7'b0110011
  - instr[11:7] = rd
  - instr[14:12] = funct3
  - instr[19:15] = rs1
  - instr[24:20] = rs2
  - instr[31:25] = funct7
- funct3/funct7 per op:
  - add 000 / 0000000
  - sub 000 / 0100000
  - sll 001 / 0000000
  - srl 101 / 0000000
  - or 110 / 0000000
  - and 111 / 0000000
- Register indices pass through unchanged, including x0.
- Illegal op (any other code):
  - Request is still accepted (handshake completes).
  - Nothing is written; count is unchanged.
  - illegal=1 for the next cycle.
  - illegal_count increments, saturating at 255.
- Pop: out_valid && out_ready at a rising edge advances the read pointer.
- Pointers wrap modulo DEPTH. Full: count==DEPTH. Empty: count==0.
- Simultaneous legal push and pop (not full, not empty): both occur; count unchanged.
- Push into empty FIFO with out_ready=1: the word is not bypassed; it is popped no earlier than the following cycle.
- When full, in_ready=0, so a concurrent pop does not enable a same-cycle push.
- Words leave in strict acceptance order.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream):
  - count=0, pointers=0, out_valid=0, out_instr=0
  - illegal=0, illegal_count=0, in_ready=1
- Latency: a word accepted at edge N has out_valid=1 after edge N (visible in cycle N+1) if the FIFO was empty.
- out_valid and out_instr come from registered state only; they never depend combinationally on in_*.
- in_ready depends only on count.
- out_instr is stable while out_valid=1 and out_ready=0.
- Throughput: one push and one pop per cycle sustained.
- Reset asserted mid-operation: all entries are discarded immediately and outputs go to reset values asynchronously. No word issues after rst_n deasserts until a new push.

## Test plan
- add x3,x1,x2 (op 0010, rd=3, rs1=1, rs2=2), out_ready=1 -> out_valid next cycle with out_instr=0x002081B3, count returns to 0.
- sub x5,x6,x7, then srl x10,x11,x12, back-to-back -> 0x407302B3 then 0x00C5D533 on consecutive cycles, in order.
- DEPTH=4, out_ready=0, push 5 legal ops -> in_ready falls after the 4th accept, count=4, 5th held. Then out_ready=1 -> four words drain in order; 5th accepted once in_ready=1; pointers wrap correctly.
- in_alu_op=0011 accepted -> illegal pulses exactly 1 cycle, illegal_count=1, count unchanged, no out_valid. 300 illegal ops -> illegal_count holds 255.
- Steady push+pop every cycle for 20 cycles -> count constant at 1, no drops or duplicates.
- FIFO holding 3 words, rst_n pulled low mid-cycle -> out_valid=0, count=0, out_instr=0 immediately. After release, no stale word appears.
